// File: rtl/mac_seq_ctrl_if.sv
// Handshake and data bundle between the MAC job sequencer, its job/chunk source,
// the MAC datapath and the result consumer.
interface mac_seq_ctrl_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int VECTOR_SIZE = 4,
    parameter int ACC_WIDTH   = 20,
    parameter int SUM_WIDTH   = 24,
    parameter int CW          = 5
);
    localparam int VW = VECTOR_SIZE * DATA_WIDTH;

    logic                 job_valid;
    logic                 job_ready;
    logic [CW-1:0]        job_len;
    logic                 chk_valid;
    logic                 chk_ready;
    logic [VW-1:0]        chk_a;
    logic [VW-1:0]        chk_b;
    logic [VW-1:0]        mac_a;
    logic [VW-1:0]        mac_b;
    logic                 mac_start;
    logic [ACC_WIDTH-1:0] mac_result;
    logic                 mac_done;
    logic                 res_valid;
    logic                 res_ready;
    logic [SUM_WIDTH-1:0] res_data;
    logic                 res_sat;
    logic                 res_err;
    logic                 busy;

    modport slave (
        input  job_valid, job_len, chk_valid, chk_a, chk_b, mac_result, mac_done, res_ready,
        output job_ready, chk_ready, mac_a, mac_b, mac_start, res_valid, res_data,
               res_sat, res_err, busy
    );

    modport master (
        output job_valid, job_len, chk_valid, chk_a, chk_b, mac_result, mac_done, res_ready,
        input  job_ready, chk_ready, mac_a, mac_b, mac_start, res_valid, res_data,
               res_sat, res_err, busy
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequences a job of N operand chunks through an external MAC, accumulating the
// results with saturation and aborting a chunk that never completes.
module mac_seq_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int VECTOR_SIZE = 4,
    parameter int ACC_WIDTH   = 20,
    parameter int SUM_WIDTH   = 24,
    parameter int MAX_CHUNKS  = 16,
    parameter int TIMEOUT     = 64,
    parameter int CW          = $clog2(MAX_CHUNKS) + 1
) (
    input  logic           clk,
    input  logic           reset,
    mac_seq_ctrl_if.slave  bus
);
    localparam int VW = VECTOR_SIZE * DATA_WIDTH;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_GUARD = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_OUT   = 3'd5;

    localparam logic [CW-1:0] MAX_LEN   = CW'(MAX_CHUNKS);
    localparam logic [CW-1:0] ONE_LEFT  = CW'(1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    logic [2:0]           r_state;
    logic [CW-1:0]        r_count;
    logic [SUM_WIDTH-1:0] r_acc;
    logic                 r_sat;
    logic                 r_err;
    logic [TW-1:0]        r_tmo;
    logic [VW-1:0]        r_mac_a;
    logic [VW-1:0]        r_mac_b;

    logic [CW-1:0]        w_len;
    logic [SUM_WIDTH:0]   w_res_ext;
    logic [SUM_WIDTH:0]   w_sum;

    assign w_len     = (bus.job_len > MAX_LEN) ? MAX_LEN : bus.job_len;
    assign w_res_ext = {{(SUM_WIDTH + 1 - ACC_WIDTH){1'b0}}, bus.mac_result};
    // One guard bit above the accumulator exposes any overflow of the true sum.
    assign w_sum     = {1'b0, r_acc} + w_res_ext;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_acc   <= '0;
            r_sat   <= 1'b0;
            r_err   <= 1'b0;
            r_tmo   <= '0;
            r_mac_a <= '0;
            r_mac_b <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.job_valid) begin
                        r_count <= w_len;
                        r_acc   <= '0;
                        r_sat   <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= (w_len == '0) ? S_OUT : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.chk_valid) begin
                        r_mac_a <= bus.chk_a;
                        r_mac_b <= bus.chk_b;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: r_state <= S_GUARD;
                S_GUARD: begin
                    // mac_done may still be high from the previous chunk here.
                    r_tmo   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.mac_done) begin
                        if (w_sum[SUM_WIDTH]) begin
                            r_acc <= '1;
                            r_sat <= 1'b1;
                        end else begin
                            r_acc <= w_sum[SUM_WIDTH-1:0];
                        end
                        r_count <= r_count - ONE_LEFT;
                        r_state <= (r_count == ONE_LEFT) ? S_OUT : S_FETCH;
                    end else if (r_tmo == TMO_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_OUT;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_OUT: begin
                    if (bus.res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.job_ready = (r_state == S_IDLE);
    assign bus.chk_ready = (r_state == S_FETCH);
    assign bus.mac_start = (r_state == S_ISSUE);
    assign bus.res_valid = (r_state == S_OUT);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.res_data  = r_acc;
    assign bus.res_sat   = r_sat;
    assign bus.res_err   = r_err;
    assign bus.mac_a     = r_mac_a;
    assign bus.mac_b     = r_mac_b;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed, table-driven bench for mac_seq_ctrl with a behavioural MAC model.
module tb_mac_seq_ctrl;
    logic clk;
    logic reset;

    mac_seq_ctrl_if #(.SUM_WIDTH(20)) bus ();

    mac_seq_ctrl #(.SUM_WIDTH(20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  len;
        logic [31:0] a;
        logic [31:0] b;
        int          result;
        bit          stale;
        int          limit;
        int          bp;
        logic [19:0] exp_data;
        bit          exp_sat;
        bit          exp_err;
        int          exp_lat;
        int          exp_starts;
    } vec_t;

    vec_t vecs[7];

    int checks = 0;
    int errors = 0;

    // MAC model state
    int          mode_limit  = 1000;
    bit          mode_stale  = 0;
    int          cur_result  = 0;
    int          starts      = 0;
    int          mac_cnt     = 0;
    logic [31:0] exp_a       = '0;
    logic [31:0] exp_b       = '0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " job_ready"}, bus.job_ready, 1);
        chk({tag, " chk_ready"}, bus.chk_ready, 0);
        chk({tag, " mac_start"}, bus.mac_start, 0);
        chk({tag, " res_valid"}, bus.res_valid, 0);
        chk({tag, " res_data"},  bus.res_data,  0);
        chk({tag, " res_sat"},   bus.res_sat,   0);
        chk({tag, " res_err"},   bus.res_err,   0);
        chk({tag, " busy"},      bus.busy,      0);
        chk({tag, " mac_a"},     bus.mac_a,     0);
        chk({tag, " mac_b"},     bus.mac_b,     0);
    endtask

    // MAC: done rises in the second half of the first WAIT cycle; done is a level
    // and, in stale mode, is never dropped at start so GUARD sees an old 1.
    always @(negedge clk) begin
        if (reset) begin
            bus.mac_done = 1'b0;
            mac_cnt = 0;
        end else begin
            if (mac_cnt > 0) begin
                mac_cnt--;
                if (mac_cnt == 0) begin
                    bus.mac_result = 20'(cur_result);
                    bus.mac_done = 1'b1;
                end
            end
            if (bus.mac_start) begin
                starts++;
                chk("mac_a at start", bus.mac_a, exp_a);
                chk("mac_b at start", bus.mac_b, exp_b);
                if (!mode_stale) bus.mac_done = 1'b0;
                if (starts <= mode_limit) mac_cnt = 2;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (int'(bus.job_ready) + int'(bus.chk_ready) + int'(bus.mac_start) > 1) begin
                errors++;
                $display("FAIL exclusive handshakes: job_ready=%0b chk_ready=%0b mac_start=%0b required at most one high",
                         bus.job_ready, bus.chk_ready, bus.mac_start);
            end
        end
    end

    task automatic run_job(input vec_t v);
        int          lat;
        logic [19:0] held;
        mode_stale = v.stale;
        mode_limit = v.limit;
        cur_result = v.result;
        starts     = 0;
        exp_a      = v.a;
        exp_b      = v.b;
        chk({v.name, " job_ready before"}, bus.job_ready, 1);
        bus.job_valid = 1'b1;
        bus.job_len   = v.len;
        bus.chk_valid = 1'b1;
        bus.chk_a     = v.a;
        bus.chk_b     = v.b;
        lat = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            bus.job_valid = 1'b0;
            lat++;
            if (bus.res_valid) break;
        end
        chk({v.name, " res_valid reached"}, bus.res_valid, 1);
        chk({v.name, " latency"},   lat,           v.exp_lat);
        chk({v.name, " res_data"},  bus.res_data,  v.exp_data);
        chk({v.name, " res_sat"},   bus.res_sat,   v.exp_sat);
        chk({v.name, " res_err"},   bus.res_err,   v.exp_err);
        chk({v.name, " job_ready in OUT"}, bus.job_ready, 0);
        held = bus.res_data;
        for (int i = 0; i < v.bp; i++) begin
            @(negedge clk);
            chk({v.name, " bp res_valid"}, bus.res_valid, 1);
            chk({v.name, " bp res_data"},  bus.res_data,  held);
            chk({v.name, " bp job_ready"}, bus.job_ready, 0);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        bus.chk_valid = 1'b0;
        chk({v.name, " res_valid after accept"}, bus.res_valid, 0);
        chk({v.name, " job_ready after accept"}, bus.job_ready, 1);
        chk({v.name, " mac_start pulses"}, starts, v.exp_starts);
    endtask

    initial begin
        //         name          len   a             b             res     st lim  bp data     sat err lat starts
        vecs[0] = '{"basic",     5'd3, 32'h04030201, 32'h01010101, 10,     0, 1000, 0, 20'd30,      0, 0, 13, 3};
        vecs[1] = '{"stale",     5'd3, 32'h01010101, 32'h07070707, 7,      1, 1000, 0, 20'd21,      0, 0, 13, 3};
        vecs[2] = '{"empty",     5'd0, 32'h0,        32'h0,        0,      0, 1000, 0, 20'd0,       0, 0, 1,  0};
        vecs[3] = '{"clamp",     5'd20,32'h04030201, 32'h01010101, 10,     0, 1000, 0, 20'd160,     0, 0, 65, 16};
        vecs[4] = '{"saturate",  5'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 260100, 0, 1000, 0, 20'd1048575, 1, 0, 21, 5};
        vecs[5] = '{"timeout",   5'd3, 32'h04030201, 32'h01010101, 10,     0, 1,    0, 20'd10,      0, 1, 72, 2};
        vecs[6] = '{"backpress", 5'd2, 32'h0A0B0C0D, 32'h01020304, 55,     0, 1000, 10,20'd110,     0, 0, 9,  2};

        reset = 1'b1;
        bus.job_valid  = 1'b0;
        bus.job_len    = '0;
        bus.chk_valid  = 1'b0;
        bus.chk_a      = '0;
        bus.chk_b      = '0;
        bus.mac_result = '0;
        bus.mac_done   = 1'b0;
        bus.res_ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        chk_reset_outputs("idle");

        foreach (vecs[i]) begin
            run_job(vecs[i]);
            $display("job %s: data=%0d sat=%0b err=%0b", vecs[i].name,
                     vecs[i].exp_data, vecs[i].exp_sat, vecs[i].exp_err);
        end

        // Reset while a chunk is stuck in WAIT.
        mode_stale = 0;
        mode_limit = 0;
        starts     = 0;
        exp_a      = 32'h11223344;
        exp_b      = 32'h55667788;
        bus.job_valid = 1'b1;
        bus.job_len   = 5'd2;
        bus.chk_valid = 1'b1;
        bus.chk_a     = exp_a;
        bus.chk_b     = exp_b;
        @(negedge clk);
        bus.job_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("midjob busy", bus.busy, 1);
        chk("midjob res_valid", bus.res_valid, 0);
        chk("midjob mac_a", bus.mac_a, 32'h11223344);
        reset = 1'b1;
        bus.chk_valid = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midjob reset");
        reset = 1'b0;
        @(negedge clk);
        run_job(vecs[0]);
        $display("job post-reset basic: data=%0d", vecs[0].exp_data);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- DATA_WIDTH, 8, operand element width.
- VECTOR_SIZE, 4, elements per chunk, equal to the MAC vector length.
- ACC_WIDTH, 20, MAC result width.
- SUM_WIDTH, 24, job accumulator width; SHALL be at least ACC_WIDTH.
- MAX_CHUNKS, 16, maximum chunks per job.
- TIMEOUT, 64, WAIT cycles before abort.
- CW, $clog2(MAX_CHUNKS)+1, chunk-count width.

REQ-002 Ports, one per line: name, direction, width, meaning:
- clk, in, 1, single clock; all logic on the rising edge.
- reset, in, 1, synchronous, active-high.
- job_valid, in, 1, job request.
- job_ready, out, 1, job accepted when high together with job_valid.
- job_len, in, CW, chunk count for the job.
- chk_valid, in, 1, chunk operands valid.
- chk_ready, out, 1, chunk accepted when high together with chk_valid.
- chk_a, in, VECTOR_SIZE*DATA_WIDTH, packed A operand vector.
- chk_b, in, VECTOR_SIZE*DATA_WIDTH, packed B operand vector.
- mac_a, out, VECTOR_SIZE*DATA_WIDTH, registered operands driven to the MAC.
- mac_b, out, VECTOR_SIZE*DATA_WIDTH, registered operands driven to the MAC.
- mac_start, out, 1, one-cycle MAC start pulse.
- mac_result, in, ACC_WIDTH, unsigned MAC result.
- mac_done, in, 1, level MAC completion flag.
- res_valid, out, 1, job result valid.
- res_ready, in, 1, result consumer ready.
- res_data, out, SUM_WIDTH, accumulated job sum.
- res_sat, out, 1, sum saturated.
- res_err, out, 1, job aborted by timeout.
- busy, out, 1, high in any state other than IDLE.

Function
REQ-003 The FSM SHALL have exactly the states IDLE, FETCH, ISSUE, GUARD, WAIT and OUT.
REQ-004 IDLE: job_ready=1; on job_valid, the block SHALL latch the chunk count, clear the accumulator, res_sat and res_err, then go to OUT if the count is 0, else to FETCH.
REQ-005 A job_len greater than MAX_CHUNKS SHALL be clamped to MAX_CHUNKS.
REQ-006 FETCH: chk_ready=1; on chk_valid, the block SHALL register chk_a/chk_b into mac_a/mac_b and go to ISSUE; otherwise it SHALL stay in FETCH indefinitely.
REQ-007 ISSUE: mac_start=1 for exactly this one cycle, then the FSM SHALL go to GUARD.
REQ-008 GUARD: the block SHALL ignore mac_done, because the level is stale from the previous operation, and go to WAIT.
REQ-009 WAIT: on mac_done=1, the block SHALL add mac_result, zero-extended, to the accumulator and decrement the remaining count; it SHALL go to OUT if the remaining count reaches 0, else to FETCH.
REQ-010 Accumulation SHALL saturate: if the true sum exceeds 2^SUM_WIDTH-1, the accumulator SHALL hold 2^SUM_WIDTH-1 and res_sat SHALL be 1 and stay 1 for the rest of the job.
REQ-011 WAIT timeout: the counter SHALL clear on WAIT entry and increment each WAIT cycle without mac_done; on reaching TIMEOUT, the block SHALL go to OUT with res_err=1 and the accumulator unchanged.
REQ-012 OUT: res_valid=1 with res_data, res_sat and res_err stable until res_ready=1, then the FSM SHALL go to IDLE.
REQ-013 The block SHALL NOT assert job_ready in the cycle it leaves OUT; the next job SHALL be accepted no earlier than the following cycle.
REQ-014 Latency: with chk_valid held high and the MAC done one cycle after GUARD, each chunk SHALL take 4 cycles, and res_valid SHALL rise 4N+1 cycles after the job handshake.
REQ-015 job_ready, chk_ready and mac_start SHALL never be high in the same cycle.
REQ-016 mac_a/mac_b SHALL remain stable from ISSUE until the next FETCH handshake.

Reset
REQ-017 reset SHALL be sampled on the rising clk edge only and SHALL override every other event, including a mid-job reset.
REQ-018 After reset: FSM in IDLE, job_ready=1, and chk_ready, mac_start, res_valid, res_data, res_sat, res_err, busy, mac_a and mac_b all 0; the accumulator, chunk count and timeout counter SHALL be 0.
REQ-019 A result pending in OUT SHALL be discarded by reset.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Basic job: job_len=3, each chunk a={1,2,3,4}, b={1,1,1,1}, MAC model returns 10 -> res_data=30, res_sat=0, res_err=0, res_valid rises 13 cycles after the job handshake.
- Empty job: job_len=0 -> res_valid next cycle, res_data=0, no mac_start pulse.
- Saturation: SUM_WIDTH=20, 5 chunks of all-255 operands, MAC returns 260100 -> res_data=1048575, res_sat=1.
- Timeout: mac_done held 0 -> res_err=1 after 64 WAIT cycles, res_data equals the sum of the chunks completed before the timeout.
- Stale done: mac_done held 1 from a prior operation -> no chunk completes in the GUARD cycle, accumulation only in WAIT.
- Backpressure and reset: res_ready low for 10 cycles keeps outputs stable; reset asserted in WAIT -> all outputs at reset values the next cycle, and a new job starts cleanly.
